// File: rtl/sa_tile_sequencer.sv
// Sequencer for one 8x8 systolic-array tile: buffer fetch, edge skew, bias load, result collection.
// Optional build macro SA_SEQ_WATCHDOG_EN adds a WAIT_OUT timeout that aborts with err_o.
module sa_tile_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 8,
    parameter int COL_NUM    = 8,
    parameter int INTER_NUM  = 8,
    parameter int AW         = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          start_i,
    input  logic [AW-1:0]                 a_base_i,
    input  logic [AW-1:0]                 w_base_i,
    input  logic [AW-1:0]                 bias_base_i,
    input  logic [AW-1:0]                 out_base_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic                          a_rd_en_o,
    output logic [AW-1:0]                 a_rd_addr_o,
    input  logic [DATA_WIDTH*ROW_NUM-1:0] a_rd_data_i,
    output logic                          w_rd_en_o,
    output logic [AW-1:0]                 w_rd_addr_o,
    input  logic [DATA_WIDTH*COL_NUM-1:0] w_rd_data_i,
    output logic                          b_rd_en_o,
    output logic [AW-1:0]                 b_rd_addr_o,
    input  logic [DATA_WIDTH*ROW_NUM-1:0] b_rd_data_i,
    output logic                          sa_iv_o,
    output logic                          sa_mac_iv_o,
    output logic                          sa_bias_iv_o,
    output logic [DATA_WIDTH*ROW_NUM-1:0] row_A_o,
    output logic [DATA_WIDTH*COL_NUM-1:0] col_W_o,
    output logic [DATA_WIDTH*ROW_NUM-1:0] bias_col_o,
    input  logic                          sa_ov_i,
    input  logic [DATA_WIDTH*COL_NUM-1:0] psum_i,
    output logic                          res_wr_en_o,
    output logic [AW-1:0]                 res_wr_addr_o,
    output logic [DATA_WIDTH*COL_NUM-1:0] res_wr_data_o
);

    localparam int MAC_LEN = INTER_NUM + ROW_NUM + COL_NUM - 2;
    // One counter serves the feed/drain window, bias beats, write index and watchdog.
    localparam int CNT_MAX = (MAC_LEN + 2 > TIMEOUT) ? MAC_LEN + 2 : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] FEED_LAST = CW'(INTER_NUM - 1);
    localparam logic [CW-1:0] MAC_FIRST = CW'(2);
    localparam logic [CW-1:0] MAC_LAST  = CW'(MAC_LEN + 1);
    localparam logic [CW-1:0] BIAS_RDS  = CW'(COL_NUM);
    localparam logic [CW-1:0] COL_LAST  = CW'(COL_NUM - 1);
`ifdef SA_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_BIAS,
        S_WAIT_OUT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [AW-1:0]   a_base_reg, a_base_next;
    logic [AW-1:0]   w_base_reg, w_base_next;
    logic [AW-1:0]   b_base_reg, b_base_next;
    logic [AW-1:0]   o_base_reg, o_base_next;
    logic            err_reg, err_next;
    logic            a_en_d_reg, w_en_d_reg, b_en_d_reg;
    logic [DATA_WIDTH*ROW_NUM-1:0] a_stage_reg;
    logic [DATA_WIDTH*COL_NUM-1:0] w_stage_reg;
    logic            mac_window;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            a_base_reg  <= '0;
            w_base_reg  <= '0;
            b_base_reg  <= '0;
            o_base_reg  <= '0;
            err_reg     <= 1'b0;
            a_en_d_reg  <= 1'b0;
            w_en_d_reg  <= 1'b0;
            b_en_d_reg  <= 1'b0;
            a_stage_reg <= '0;
            w_stage_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            a_base_reg  <= a_base_next;
            w_base_reg  <= w_base_next;
            b_base_reg  <= b_base_next;
            o_base_reg  <= o_base_next;
            err_reg     <= err_next;
            a_en_d_reg  <= a_rd_en_o;
            w_en_d_reg  <= w_rd_en_o;
            b_en_d_reg  <= b_rd_en_o;
            // Only beats that were actually read enter the skew; idle lanes carry zeros.
            a_stage_reg <= a_en_d_reg ? a_rd_data_i : '0;
            w_stage_reg <= w_en_d_reg ? w_rd_data_i : '0;
        end
    end

    assign mac_window = (cnt_reg >= MAC_FIRST) && (cnt_reg <= MAC_LAST);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        a_base_next   = a_base_reg;
        w_base_next   = w_base_reg;
        b_base_next   = b_base_reg;
        o_base_next   = o_base_reg;
        err_next      = err_reg;
        busy_o        = (state_reg != S_IDLE);
        done_o        = 1'b0;
        err_o         = err_reg;
        a_rd_en_o     = 1'b0;
        a_rd_addr_o   = '0;
        w_rd_en_o     = 1'b0;
        w_rd_addr_o   = '0;
        b_rd_en_o     = 1'b0;
        b_rd_addr_o   = '0;
        sa_iv_o       = 1'b0;
        sa_mac_iv_o   = 1'b0;
        sa_bias_iv_o  = 1'b0;
        bias_col_o    = '0;
        res_wr_en_o   = 1'b0;
        res_wr_addr_o = '0;
        res_wr_data_o = '0;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    a_base_next = a_base_i;
                    w_base_next = w_base_i;
                    b_base_next = bias_base_i;
                    o_base_next = out_base_i;
                    err_next    = 1'b0;
                    cnt_next    = '0;
                    state_next  = S_FEED;
                end
            end
            S_FEED: begin
                sa_iv_o     = 1'b1;
                sa_mac_iv_o = mac_window;
                a_rd_en_o   = 1'b1;
                w_rd_en_o   = 1'b1;
                a_rd_addr_o = a_base_reg + AW'(cnt_reg);
                w_rd_addr_o = w_base_reg + AW'(cnt_reg);
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == FEED_LAST) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                sa_iv_o     = 1'b1;
                sa_mac_iv_o = mac_window;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == MAC_LAST) begin
                    cnt_next   = '0;
                    state_next = S_BIAS;
                end
            end
            S_BIAS: begin
                sa_iv_o = 1'b1;
                if (cnt_reg < BIAS_RDS) begin
                    b_rd_en_o   = 1'b1;
                    b_rd_addr_o = b_base_reg + AW'(cnt_reg);
                end
                // Strobe follows the read by one cycle so it lines up with returned data.
                sa_bias_iv_o = b_en_d_reg;
                bias_col_o   = b_en_d_reg ? b_rd_data_i : '0;
                cnt_next     = cnt_reg + 1'b1;
                if (cnt_reg == BIAS_RDS) begin
                    cnt_next   = '0;
                    state_next = S_WAIT_OUT;
                end
            end
            S_WAIT_OUT: begin
                sa_iv_o = 1'b1;
                if (sa_ov_i) begin
                    res_wr_en_o   = 1'b1;
                    res_wr_addr_o = o_base_reg;
                    res_wr_data_o = psum_i;
                    cnt_next      = CW'(1);
                    state_next    = (COL_NUM == 1) ? S_DONE : S_WRITE;
                end
`ifdef SA_SEQ_WATCHDOG_EN
                else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == WD_LAST) begin
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end
                end
`endif
            end
            S_WRITE: begin
                sa_iv_o = 1'b1;
                if (sa_ov_i) begin
                    res_wr_en_o   = 1'b1;
                    res_wr_addr_o = o_base_reg + AW'(cnt_reg);
                    res_wr_data_o = psum_i;
                    cnt_next      = cnt_reg + 1'b1;
                    if (cnt_reg == COL_LAST) begin
                        state_next = S_DONE;
                    end
                end else begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Lane gi of each edge is delayed gi cycles beyond the common stage register.
    for (genvar gi = 0; gi < ROW_NUM; gi++) begin : g_a_skew
        if (gi == 0) begin : g_direct
            assign row_A_o[0 +: DATA_WIDTH] = a_stage_reg[0 +: DATA_WIDTH];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] dly_reg [gi];
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int i = 0; i < gi; i++) dly_reg[i] <= '0;
                end else begin
                    dly_reg[0] <= a_stage_reg[gi*DATA_WIDTH +: DATA_WIDTH];
                    for (int i = 1; i < gi; i++) dly_reg[i] <= dly_reg[i-1];
                end
            end
            assign row_A_o[gi*DATA_WIDTH +: DATA_WIDTH] = dly_reg[gi-1];
        end
    end

    for (genvar gi = 0; gi < COL_NUM; gi++) begin : g_w_skew
        if (gi == 0) begin : g_direct
            assign col_W_o[0 +: DATA_WIDTH] = w_stage_reg[0 +: DATA_WIDTH];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] dly_reg [gi];
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int i = 0; i < gi; i++) dly_reg[i] <= '0;
                end else begin
                    dly_reg[0] <= w_stage_reg[gi*DATA_WIDTH +: DATA_WIDTH];
                    for (int i = 1; i < gi; i++) dly_reg[i] <= dly_reg[i-1];
                end
            end
            assign col_W_o[gi*DATA_WIDTH +: DATA_WIDTH] = dly_reg[gi-1];
        end
    end

endmodule

// File: doc/sa_tile_sequencer.md
Name: sa_tile_sequencer

Overview:
- Controller that runs one complete matrix-tile operation on the 8x8 systolic array.
- Fetches A columns, W rows and bias vectors from local tile buffers, skews them into the array edges, and drives the array's sa_iv / sa_mac_iv / sa_bias_iv controls.
- Collects the COL_NUM quantized output vectors while the array's sa_ov is high and writes them to the result buffer.
- Sits between the layer scheduler (start/done handshake) and the Systolic_array datapath.

Parameters:
- DATA_WIDTH, 8, element width of A/W/bias/result.
- ROW_NUM, 8, array rows (m); number of A lanes.
- COL_NUM, 8, array columns (n); number of W lanes and output vectors.
- INTER_NUM, 8, inner dimension (l); number of feed beats.
- AW, 8, buffer address width.
- TIMEOUT, 64, WAIT_OUT watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle request, sampled only in IDLE
- a_base_i, w_base_i, bias_base_i, out_base_i  in  AW each  buffer base addresses, latched on accepted start
- busy_o  out  1  high from accepted start until the DONE cycle inclusive
- done_o  out  1  one-cycle pulse on completion
- err_o  out  1  sticky error; cleared by the next accepted start
- a_rd_en_o / a_rd_addr_o  out  1/AW  A buffer read (data 1 cycle later)
- a_rd_data_i  in  DATA_WIDTH*ROW_NUM  A column, lane k in bits [k*DW+:DW]
- w_rd_en_o / w_rd_addr_o  out  1/AW  W buffer read
- w_rd_data_i  in  DATA_WIDTH*COL_NUM  W row
- b_rd_en_o / b_rd_addr_o  out  1/AW  bias buffer read
- b_rd_data_i  in  DATA_WIDTH*ROW_NUM  bias column
- sa_iv_o, sa_mac_iv_o, sa_bias_iv_o  out  1 each  array controls
- row_A_o  out  DATA_WIDTH*ROW_NUM  skewed A to array
- col_W_o  out  DATA_WIDTH*COL_NUM  skewed W to array
- bias_col_o  out  DATA_WIDTH*ROW_NUM  bias column to array
- sa_ov_i  in  1  array output valid
- psum_i  in  DATA_WIDTH*COL_NUM  array output vector
- res_wr_en_o / res_wr_addr_o / res_wr_data_o  out  1/AW/DATA_WIDTH*COL_NUM  result write

Behaviour:
- Reset: every output is 0; state IDLE; skew registers and counters cleared. Reset mid-operation aborts immediately with no done_o.
- States: IDLE, FEED, DRAIN, BIAS, WAIT_OUT, WRITE, DONE.
- IDLE:
  - start_i=1 latches the bases, clears err_o, and moves to FEED on the next edge.
  - start_i while busy is ignored.
- FEED (INTER_NUM cycles, beat k=0..INTER_NUM-1):
  - a_rd_en_o=w_rd_en_o=1; a_rd_addr_o=a_base+k; w_rd_addr_o=w_base+k.
- Skew:
  - Returned data is registered once; lane k of A and lane k of W are then delayed by k further cycles.
  - Lanes with no valid data drive 0.
  - Lane 0 of row_A_o shows A beat 0 exactly 2 cycles after the first FEED cycle.
- sa_iv_o: high from the first FEED cycle through the last WRITE cycle.
- sa_mac_iv_o: high for exactly MAC_LEN = INTER_NUM+ROW_NUM+COL_NUM-2 consecutive cycles, starting when lane 0 data first reaches the array. Covers FEED tail plus DRAIN.
- DRAIN: zero-feeds until MAC_LEN expires, then moves to BIAS.
- BIAS (COL_NUM+1 cycles):
  - Reads bias_base+c for c=0..COL_NUM-1.
  - sa_bias_iv_o is high for exactly COL_NUM cycles, aligned with returned data on bias_col_o (first cycle has no strobe).
- WAIT_OUT: waits for sa_ov_i=1, then enters WRITE in the same cycle the first vector is captured.
- WRITE:
  - Each cycle with sa_ov_i=1: res_wr_en_o=1, res_wr_addr_o=out_base+j, res_wr_data_o=psum_i (combinational pass, no extra latency), j=0..COL_NUM-1.
  - After COL_NUM writes → DONE.
  - sa_ov_i falling before COL_NUM writes: set err_o, go to DONE.
- DONE: done_o=1 for one cycle, busy_o still 1; next state IDLE.
- Address arithmetic wraps modulo 2^AW. No other address checking.

Optional Feature:
- Macro SA_SEQ_WATCHDOG_EN.
- Defined: a counter runs in WAIT_OUT. If sa_ov_i has not risen after TIMEOUT cycles, set err_o, drop sa_iv_o, and go to DONE (done_o still pulses).
- Not defined: WAIT_OUT waits indefinitely; err_o is set only by an early sa_ov_i drop.

Test Plan:
- Reset mid-FEED (nrst low at beat 3) → all outputs 0 immediately, state IDLE, no done_o; a following start runs a full tile normally.
- A=identity, W=k+1 per row, bias=0, array model → 8 result writes at out_base..out_base+7 matching the reference product; sa_mac_iv_o high exactly 22 cycles; done_o 1 cycle after the 8th write.
- Skew check with a_base=0x10: cycle FEED+2 row_A_o lane0=A[0], lanes1-7=0; cycle FEED+9 lane7=A[0] lane7.
- start_i held high during a whole tile → exactly one tile executes; second start accepted only in IDLE after done_o.
- out_base=0xFC → writes to 0xFC,0xFD,0xFE,0xFF,0x00..0x03; sa_ov_i dropped after 5 vectors in another run → err_o=1, done_o pulses, err_o cleared by next start.
- SA_SEQ_WATCHDOG_EN, TIMEOUT=64, sa_ov_i held 0 → err_o=1 and done_o 64 cycles after WAIT_OUT entry; without the macro, busy_o stays 1.
